// File: rtl/p_reg3_dma.sv
// rtl/p_reg3_dma.sv - parasite memory to register-3 FIFO block-transfer engine
module p_reg3_dma #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  p_phi2,
  input  logic                  h_rst_b,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  one_byte_mode,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  input  logic                  p_full,
  input  logic                  p_empty,
  output logic [7:0]            p_data,
  output logic                  p_selectData,
  output logic                  p_rdnw,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_SPACE,
    S_WRITE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                 mode_one;   // latched register-3 mode
  logic                 pad_en;     // transfer ends with a 0x00 pad byte
  logic                 phase;      // 0 = first byte of a pair, 1 = second
  logic                 pad_now;
  logic                 next_pad;
  logic                 space_ok;
  logic                 len_odd2;
  logic [LEN_WIDTH:0]   length_up;
  logic [LEN_WIDTH-1:0] length_eff;
  logic                 pad_start;

  // Round odd two-byte lengths up to a whole pair. An all-ones odd length
  // cannot be rounded up, so it is rounded down instead and gets no pad.
  always_comb begin
    len_odd2   = !one_byte_mode && length[0];
    length_up  = {1'b0, length} + (LEN_WIDTH+1)'(1);
    length_eff = length;
    pad_start  = 1'b0;
    if (len_odd2) begin
      if (length_up[LEN_WIDTH]) begin
        length_eff = length - LEN_WIDTH'(1);
      end else begin
        length_eff = length_up[LEN_WIDTH-1:0];
        pad_start  = 1'b1;
      end
    end
  end

  // Pad detection and FIFO space condition for the current byte.
  always_comb begin
    pad_now  = pad_en && (remaining == LEN_WIDTH'(1));
    next_pad = (state_q == S_WRITE) && pad_en && (remaining == LEN_WIDTH'(2));
    if (mode_one) begin
      space_ok = !p_full;
    end else if (phase) begin
      space_ok = 1'b1;
    end else begin
      space_ok = p_empty;
    end
  end

  // State register.
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort while busy overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && (length_eff != '0)) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pad_now || (mem_req && mem_ack)) begin
          state_d = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (space_ok) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (remaining == LEN_WIDTH'(1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and transfer bookkeeping.
  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      p_data       <= 8'h00;
      p_selectData <= 1'b0;
      p_rdnw       <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      remaining    <= '0;
      mode_one     <= 1'b1;
      pad_en       <= 1'b0;
      phase        <= 1'b0;
    end else begin
      // Request and strobe follow the next state so both are registered.
      mem_req      <= (state_d == S_FETCH) && !next_pad;
      p_selectData <= (state_d == S_WRITE);
      p_rdnw       <= (state_d != S_WRITE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mem_addr  <= src_addr;
            mode_one  <= one_byte_mode;
            pad_en    <= pad_start;
            remaining <= length_eff;
            phase     <= 1'b0;
            aborted   <= 1'b0;
            busy      <= (length_eff != '0);
            done      <= (length_eff == '0);
          end
        end
        default: begin
          if (abort) begin
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            case (state_q)
              S_FETCH: begin
                if (pad_now) begin
                  p_data <= 8'h00;
                end else if (mem_req && mem_ack) begin
                  p_data   <= mem_rdata;
                  mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
              end
              S_WRITE: begin
                remaining <= remaining - LEN_WIDTH'(1);
                phase     <= ~phase;
                if (remaining == LEN_WIDTH'(1)) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
